// File: rtl/tetris_game_ctrl.sv
// Game-flow scheduler for the falling-piece datapath. It decides when the
// active piece spawns, shifts, steps down or locks. After a lock it scans the
// board bottom-up and issues row clears, and it tracks cleared lines and level.
module tetris_game_ctrl #(
  parameter int ROWS      = 20,
  parameter int GRAV_INIT = 50,
  parameter int GRAV_STEP = 4,
  parameter int GRAV_MIN  = 8,
  parameter int LPL       = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_tick,
  input  logic [1:0] i_move_req,
  input  logic       i_blocked_l,
  input  logic       i_blocked_r,
  input  logic       i_blocked_d,
  input  logic       i_spawn_ok,
  input  logic       i_row_full,
  output logic       o_spawn,
  output logic       o_step_down,
  output logic [1:0] o_shift,
  output logic       o_lock,
  output logic       o_clear_row,
  output logic [4:0] o_scan_row,
  output logic [2:0] o_state,
  output logic       o_game_over,
  output logic [9:0] o_lines,
  output logic [3:0] o_level
);

  localparam int PW  = $clog2(GRAV_INIT + 1);
  localparam int LCW = (LPL > 1) ? $clog2(LPL) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_FALL  = 3'd2,
    S_LOCK  = 3'd3,
    S_SCAN  = 3'd4,
    S_CLEAR = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  state_t          r_state, w_state_next;
  logic            r_spawn, w_spawn_next;
  logic            r_step_down, w_step_down_next;
  logic [1:0]      r_shift, w_shift_next;
  logic            r_lock, w_lock_next;
  logic            r_clear_row, w_clear_row_next;
  logic [4:0]      r_scan_row, w_scan_row_next;
  logic            r_game_over;
  logic [9:0]      r_lines, w_lines_next;
  logic [3:0]      r_level, w_level_next;
  logic [LCW-1:0]  r_lvl_cnt, w_lvl_cnt_next;
  logic [PW-1:0]   r_grav_cnt, w_grav_cnt_next;
  logic [PW-1:0]   r_period, w_period_next;

  // Gravity period for the current level, clamped at the minimum; it is only
  // latched on a spawn so a level-up mid-piece does not speed the piece up.
  int              w_level_dec;
  logic [PW-1:0]   w_period_calc;
  assign w_level_dec   = int'(r_level) * GRAV_STEP;
  assign w_period_calc = (GRAV_INIT - w_level_dec <= GRAV_MIN) ? PW'(GRAV_MIN)
                                                                : PW'(GRAV_INIT - w_level_dec);

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state_next     = r_state;
    w_spawn_next     = 1'b0;
    w_step_down_next = 1'b0;
    w_shift_next     = 2'd0;
    w_lock_next      = 1'b0;
    w_clear_row_next = 1'b0;
    w_scan_row_next  = r_scan_row;
    w_lines_next     = r_lines;
    w_level_next     = r_level;
    w_lvl_cnt_next   = r_lvl_cnt;
    w_grav_cnt_next  = r_grav_cnt;
    w_period_next    = r_period;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (i_start) begin
          w_lines_next   = '0;
          w_level_next   = '0;
          w_lvl_cnt_next = '0;
          w_state_next   = S_SPAWN;
        end
      end
      S_SPAWN: begin
        if (i_spawn_ok) begin
          w_spawn_next    = 1'b1;
          w_grav_cnt_next = '0;
          w_period_next   = w_period_calc;
          w_state_next    = S_FALL;
        end else begin
          w_state_next = S_OVER;
        end
      end
      S_FALL: begin
        if (i_tick) begin
          if (r_grav_cnt == r_period - PW'(1)) begin
            // Gravity due: the move request on this tick is dropped.
            w_grav_cnt_next = '0;
            if (i_blocked_d) w_state_next = S_LOCK;
            else             w_step_down_next = 1'b1;
          end else begin
            w_grav_cnt_next = r_grav_cnt + PW'(1);
            if (i_move_req == 2'd1 && !i_blocked_l) w_shift_next = 2'd1;
            if (i_move_req == 2'd2 && !i_blocked_r) w_shift_next = 2'd2;
          end
        end
      end
      S_LOCK: begin
        w_lock_next     = 1'b1;
        w_scan_row_next = 5'(ROWS - 1);
        w_state_next    = S_SCAN;
      end
      S_SCAN: begin
        if (i_row_full) begin
          w_clear_row_next = 1'b1;
          if (r_lines != 10'd1023) w_lines_next = r_lines + 10'd1;
          if (r_lvl_cnt == LCW'(LPL - 1)) begin
            w_lvl_cnt_next = '0;
            if (r_level != 4'd15) w_level_next = r_level + 4'd1;
          end else begin
            w_lvl_cnt_next = r_lvl_cnt + LCW'(1);
          end
          w_state_next = S_CLEAR;
        end else if (r_scan_row == 5'd0) begin
          w_state_next = S_SPAWN;
        end else begin
          w_scan_row_next = r_scan_row - 5'd1;
        end
      end
      // Rows above have shifted down into scan_row, so rescan the same row.
      S_CLEAR: w_state_next = S_SCAN;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_spawn     <= 1'b0;
      r_step_down <= 1'b0;
      r_shift     <= 2'd0;
      r_lock      <= 1'b0;
      r_clear_row <= 1'b0;
      r_scan_row  <= 5'd0;
      r_game_over <= 1'b0;
      r_lines     <= 10'd0;
      r_level     <= 4'd0;
      r_lvl_cnt   <= '0;
      r_grav_cnt  <= '0;
      r_period    <= PW'(GRAV_INIT);
    end else begin
      r_state     <= w_state_next;
      r_spawn     <= w_spawn_next;
      r_step_down <= w_step_down_next;
      r_shift     <= w_shift_next;
      r_lock      <= w_lock_next;
      r_clear_row <= w_clear_row_next;
      r_scan_row  <= w_scan_row_next;
      r_game_over <= (w_state_next == S_OVER);
      r_lines     <= w_lines_next;
      r_level     <= w_level_next;
      r_lvl_cnt   <= w_lvl_cnt_next;
      r_grav_cnt  <= w_grav_cnt_next;
      r_period    <= w_period_next;
    end
  end

  assign o_spawn     = r_spawn;
  assign o_step_down = r_step_down;
  assign o_shift     = r_shift;
  assign o_lock      = r_lock;
  assign o_clear_row = r_clear_row;
  assign o_scan_row  = r_scan_row;
  assign o_state     = r_state;
  assign o_game_over = r_game_over;
  assign o_lines     = r_lines;
  assign o_level     = r_level;

endmodule
